// File: rtl/ctr_slot_sched.sv
// Counter-slot scheduler: arbitrates PINC/MINC requests from the involuntary counters
// onto the sequencer's single counter slot. Optional BUSY watchdog under CTR_WDOG_EN.
module ctr_slot_sched #(
  parameter int              NUM_CTR    = 5,
  parameter logic [15:0]     BASE_ADDR  = 16'o0034,
  parameter logic [NUM_CTR-1:0] CHAIN_MASK = 5'b00100
`ifdef CTR_WDOG_EN
  , parameter int            WDOG_CYCLES = 64
`endif
) (
  input  logic               CLK2,
  input  logic               RST,
  input  logic [NUM_CTR-1:0] PINC_REQ,
  input  logic [NUM_CTR-1:0] MINC_REQ,
  input  logic               SLOT_GNT,
  input  logic               CTR_DONE,
  input  logic               CTR_OVF,
  output logic               SLOT_REQ,
  output logic               CTR_VALID,
  output logic [15:0]        CTR_ADDR,
  output logic [1:0]         CTR_OP,
  output logic [NUM_CTR-1:0] OVF_PULSE,
`ifdef CTR_WDOG_EN
  output logic               WDOG_ERR,
`endif
  output logic               DROP_ERR
);

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_BUSY = 2'd2;
  localparam logic [1:0] OP_NONE = 2'b00, OP_PINC = 2'b01, OP_MINC = 2'b10;
  localparam int IW = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;

  logic [1:0]         r_state, w_state_nxt;
  logic [NUM_CTR-1:0] r_pend_p, r_pend_m;
  logic [IW-1:0]      r_svc_idx;
  logic               r_slot_req, r_ctr_valid, r_drop_err;
  logic [15:0]        r_ctr_addr;
  logic [1:0]         r_ctr_op;
  logic [NUM_CTR-1:0] r_ovf_pulse;

  logic [NUM_CTR-1:0] w_live, w_cancel, w_svc_1h, w_sel_1h, w_chain_p;
  logic [NUM_CTR-1:0] w_rst_p, w_rst_m, w_req_p, w_req_m, w_lost;
  logic [NUM_CTR-1:0] w_set_p, w_set_m, w_pend_p_nxt, w_pend_m_nxt;
  logic [IW-1:0]      w_sel_idx;
  logic [1:0]         w_sel_op;
  logic               w_any_live, w_gnt, w_done, w_ovf, w_abort;

  assign w_live     = r_pend_p ^ r_pend_m;
  assign w_cancel   = r_pend_p & r_pend_m;
  assign w_any_live = |w_live;
  assign w_svc_1h   = NUM_CTR'(1) << r_svc_idx;
  assign w_done     = (r_state == S_BUSY) && CTR_DONE;
  assign w_ovf      = w_done && CTR_OVF;
  assign w_gnt      = (r_state == S_REQ) && SLOT_GNT && w_any_live;
  assign w_sel_1h   = NUM_CTR'(1) << w_sel_idx;

  // Only a PINC overflow carries into the next-lower counter.
  assign w_chain_p = (w_ovf && r_ctr_op == OP_PINC) ? ((w_svc_1h & CHAIN_MASK) >> 1)
                                                     : '0;

`ifdef CTR_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] r_wdog;
  logic          r_wdog_err;

  assign w_abort  = (r_state == S_BUSY) && !CTR_DONE && (r_wdog == WW'(WDOG_CYCLES - 1));
  assign WDOG_ERR = r_wdog_err;

  always_ff @(posedge CLK2 or posedge RST) begin
    if (RST) begin
      r_wdog     <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (w_gnt)                  r_wdog <= '0;
      else if (r_state == S_BUSY) r_wdog <= r_wdog + 1'b1;
      if (w_abort)                r_wdog_err <= 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  assign w_rst_p = (w_abort && r_ctr_op == OP_PINC) ? w_svc_1h : '0;
  assign w_rst_m = (w_abort && r_ctr_op == OP_MINC) ? w_svc_1h : '0;
  assign w_req_p = PINC_REQ | w_chain_p | w_rst_p;
  assign w_req_m = MINC_REQ | w_rst_m;

  // A request is lost if its pending bit is already set or two sources hit the same bit.
  assign w_lost = (w_req_p & r_pend_p) | (w_req_m & r_pend_m)
                | (PINC_REQ & (w_chain_p | w_rst_p)) | (MINC_REQ & w_rst_m);

  assign w_set_p = w_req_p & ~w_req_m & ~r_pend_p;
  assign w_set_m = w_req_m & ~w_req_p & ~r_pend_m;
  assign w_pend_p_nxt = (r_pend_p & ~w_cancel & ~(w_gnt ? w_sel_1h : '0)) | w_set_p;
  assign w_pend_m_nxt = (r_pend_m & ~w_cancel & ~(w_gnt ? w_sel_1h : '0)) | w_set_m;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_idx = '0;
    w_sel_op  = OP_NONE;
    for (int i = NUM_CTR - 1; i >= 0; i--) begin
      if (w_live[i]) begin
        w_sel_idx = IW'(i);
        w_sel_op  = r_pend_p[i] ? OP_PINC : OP_MINC;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any_live) w_state_nxt = S_REQ;
      S_REQ: begin
        if (!w_any_live)   w_state_nxt = S_IDLE;
        else if (SLOT_GNT) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_done)       w_state_nxt = (|(w_pend_p_nxt | w_pend_m_nxt)) ? S_REQ : S_IDLE;
        else if (w_abort) w_state_nxt = S_REQ;
      end
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK2 or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_pend_p    <= '0;
      r_pend_m    <= '0;
      r_svc_idx   <= '0;
      r_slot_req  <= 1'b0;
      r_ctr_valid <= 1'b0;
      r_ctr_addr  <= BASE_ADDR;
      r_ctr_op    <= OP_NONE;
      r_ovf_pulse <= '0;
      r_drop_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_p    <= w_pend_p_nxt;
      r_pend_m    <= w_pend_m_nxt;
      r_slot_req  <= (w_state_nxt == S_REQ);
      r_ovf_pulse <= w_ovf ? w_svc_1h : '0;
      r_drop_err  <= r_drop_err | (|w_lost);
      if (w_gnt) begin
        r_svc_idx   <= w_sel_idx;
        r_ctr_valid <= 1'b1;
        r_ctr_addr  <= BASE_ADDR + 16'(w_sel_idx);
        r_ctr_op    <= w_sel_op;
      end else if (w_done || w_abort) begin
        r_ctr_valid <= 1'b0;
        r_ctr_op    <= OP_NONE;
      end
    end
  end

  assign SLOT_REQ  = r_slot_req;
  assign CTR_VALID = r_ctr_valid;
  assign CTR_ADDR  = r_ctr_addr;
  assign CTR_OP    = r_ctr_op;
  assign OVF_PULSE = r_ovf_pulse;
  assign DROP_ERR  = r_drop_err;

endmodule

// File: tb/tb_ctr_slot_sched.sv
// Self-checking bench for ctr_slot_sched (default build): vector table plus hand sequences.
module tb_ctr_slot_sched;

  logic        CLK2 = 1'b0;
  logic        RST;
  logic [4:0]  PINC_REQ, MINC_REQ;
  logic        SLOT_GNT, CTR_DONE, CTR_OVF;
  logic        SLOT_REQ, CTR_VALID, DROP_ERR;
  logic [15:0] CTR_ADDR;
  logic [1:0]  CTR_OP;
  logic [4:0]  OVF_PULSE;

  ctr_slot_sched dut (
    .CLK2(CLK2), .RST(RST), .PINC_REQ(PINC_REQ), .MINC_REQ(MINC_REQ),
    .SLOT_GNT(SLOT_GNT), .CTR_DONE(CTR_DONE), .CTR_OVF(CTR_OVF),
    .SLOT_REQ(SLOT_REQ), .CTR_VALID(CTR_VALID), .CTR_ADDR(CTR_ADDR),
    .CTR_OP(CTR_OP), .OVF_PULSE(OVF_PULSE), .DROP_ERR(DROP_ERR)
  );

  always #5 CLK2 = ~CLK2;

  typedef struct {
    logic [4:0]  pinc;
    logic [4:0]  minc;
    logic [15:0] addr;
    logic [1:0]  op;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  op;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK2);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] p, input logic [4:0] m);
    PINC_REQ = p;
    MINC_REQ = m;
    tick();
    PINC_REQ = '0;
    MINC_REQ = '0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (SLOT_REQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, SLOT_REQ, 1);
  endtask

  task automatic grant();
    SLOT_GNT = 1'b1;
    tick();
    SLOT_GNT = 1'b0;
  endtask

  task automatic expect_slot(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_valid"}, CTR_VALID, 1);
      check({name, "_addr"}, CTR_ADDR, e.addr);
      check({name, "_op"}, CTR_OP, e.op);
      check({name, "_slot_req"}, SLOT_REQ, 0);
    end
  endtask

  task automatic done(input logic ovf, input logic [4:0] pinc);
    CTR_DONE = 1'b1;
    CTR_OVF  = ovf;
    PINC_REQ = pinc;
    tick();
    CTR_DONE = 1'b0;
    CTR_OVF  = 1'b0;
    PINC_REQ = '0;
  endtask

  initial begin
    PINC_REQ = '0; MINC_REQ = '0;
    SLOT_GNT = 1'b0; CTR_DONE = 1'b0; CTR_OVF = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vecs[2*i]   = '{pinc: 5'(1 << i), minc: 5'b0,          addr: 16'o0034 + 16'(i), op: 2'b01};
      vecs[2*i+1] = '{pinc: 5'b0,          minc: 5'(1 << i), addr: 16'o0034 + 16'(i), op: 2'b10};
    end

    // Reset values
    RST = 1'b1;
    tick();
    check("rst_slot_req", SLOT_REQ, 0);
    check("rst_valid", CTR_VALID, 0);
    check("rst_addr", CTR_ADDR, 16'o0034);
    check("rst_op", CTR_OP, 0);
    check("rst_ovf", OVF_PULSE, 0);
    check("rst_drop", DROP_ERR, 0);
    tick();
    RST = 1'b0;

    // Single PINC on counter 2
    pulse(5'b00100, 5'b0);
    check("t1_req_latency", SLOT_REQ, 0);
    tick();
    check("t1_req", SLOT_REQ, 1);
    sb.push_back('{addr: 16'o0036, op: 2'b01});
    grant();
    expect_slot("t1");
    done(1'b0, 5'b0);
    check("t1_done_valid", CTR_VALID, 0);
    check("t1_done_op", CTR_OP, 0);
    check("t1_done_slot_req", SLOT_REQ, 0);
    tick();
    check("t1_idle", SLOT_REQ, 0);

    // Two requests, fixed priority, third grant unused
    pulse(5'b10010, 5'b0);
    wait_req("t2_req_a");
    sb.push_back('{addr: 16'o0035, op: 2'b01});
    grant();
    expect_slot("t2_a");
    done(1'b0, 5'b0);
    wait_req("t2_req_b");
    sb.push_back('{addr: 16'o0040, op: 2'b01});
    grant();
    expect_slot("t2_b");
    done(1'b0, 5'b0);
    grant();
    check("t2_no_third", CTR_VALID, 0);

    // PINC then MINC on counter 0 cancel out
    pulse(5'b00001, 5'b0);
    pulse(5'b0, 5'b00001);
    check("t3_req_up", SLOT_REQ, 1);
    tick();
    check("t3_req_down", SLOT_REQ, 0);
    grant();
    check("t3_no_slot", CTR_VALID, 0);
    check("t3_slot_req", SLOT_REQ, 0);

    // Same-cycle PINC and MINC set nothing
    pulse(5'b00010, 5'b00010);
    tick();
    check("sim_no_req", SLOT_REQ, 0);
    check("sim_no_drop", DROP_ERR, 0);

    // MINC overflow pulses but never chains
    pulse(5'b0, 5'b00100);
    wait_req("movf_req");
    sb.push_back('{addr: 16'o0036, op: 2'b10});
    grant();
    expect_slot("movf");
    done(1'b1, 5'b0);
    check("movf_pulse", OVF_PULSE, 5'b00100);
    check("movf_no_chain", SLOT_REQ, 0);
    tick();
    check("movf_pulse_end", OVF_PULSE, 0);
    check("movf_still_idle", SLOT_REQ, 0);

    // Vector table: every counter, both directions
    for (int k = 0; k < 10; k++) begin
      pulse(vecs[k].pinc, vecs[k].minc);
      wait_req($sformatf("vec%0d_req", k));
      sb.push_back('{addr: vecs[k].addr, op: vecs[k].op});
      grant();
      expect_slot($sformatf("vec%0d", k));
      done(1'b0, 5'b0);
      check($sformatf("vec%0d_end", k), CTR_VALID, 0);
    end
    check("vec_no_drop", DROP_ERR, 0);

    // PINC overflow on counter 2 chains into counter 1
    pulse(5'b00100, 5'b0);
    wait_req("chain_req");
    sb.push_back('{addr: 16'o0036, op: 2'b01});
    grant();
    expect_slot("chain_src");
    done(1'b1, 5'b0);
    check("chain_pulse", OVF_PULSE, 5'b00100);
    check("chain_req_up", SLOT_REQ, 1);
    tick();
    check("chain_pulse_end", OVF_PULSE, 0);
    sb.push_back('{addr: 16'o0035, op: 2'b01});
    wait_req("chain_req2");
    grant();
    expect_slot("chain_dst");
    done(1'b0, 5'b0);
    check("chain_no_drop", DROP_ERR, 0);

    // Chain colliding with external PINC_REQ[1]
    pulse(5'b00100, 5'b0);
    wait_req("coll_req");
    sb.push_back('{addr: 16'o0036, op: 2'b01});
    grant();
    expect_slot("coll_src");
    done(1'b1, 5'b00010);
    check("coll_drop", DROP_ERR, 1);
    sb.push_back('{addr: 16'o0035, op: 2'b01});
    wait_req("coll_req2");
    grant();
    expect_slot("coll_dst");
    done(1'b0, 5'b0);
    tick();
    check("coll_one_slot", SLOT_REQ, 0);

    // Double PINC on counter 3 before grant
    do_reset();
    check("dbl_drop_clear", DROP_ERR, 0);
    pulse(5'b01000, 5'b0);
    pulse(5'b01000, 5'b0);
    check("dbl_drop", DROP_ERR, 1);
    wait_req("dbl_req");
    sb.push_back('{addr: 16'o0037, op: 2'b01});
    grant();
    expect_slot("dbl");
    done(1'b0, 5'b0);
    tick();
    check("dbl_one_slot", SLOT_REQ, 0);
    check("dbl_drop_sticky", DROP_ERR, 1);

    // Asynchronous reset while BUSY
    pulse(5'b00001, 5'b0);
    wait_req("rb_req");
    sb.push_back('{addr: 16'o0034, op: 2'b01});
    grant();
    expect_slot("rb");
    #2 RST = 1'b1;
    #1;
    check("rb_valid", CTR_VALID, 0);
    check("rb_slot_req", SLOT_REQ, 0);
    check("rb_addr", CTR_ADDR, 16'o0034);
    check("rb_op", CTR_OP, 0);
    check("rb_drop", DROP_ERR, 0);
    check("rb_ovf", OVF_PULSE, 0);
    tick();
    RST = 1'b0;
    tick();
    check("rb_after", SLOT_REQ, 0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
